// File: rtl/vdp_pkg.sv
// Shared types for the vdp clk_draw domain: requester ids, read-return tag
// and a saturating counter helper used by the optional statistics block.
package vdp_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_DISP = 2'd0,
        REQ_DRAW = 2'd1,
        REQ_HOST = 2'd2
    } vram_req_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } vram_tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Read-return tag delay line: carries (valid, id) alongside the memory read
// latency so returning data can be steered to the requester that issued it.
module vram_rd_tag_pipe
    import vdp_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic      clk_draw,
    input  logic      rst_draw,
    input  vram_tag_t tag_in,
    output vram_tag_t tag_out
);

    vram_tag_t [RD_LAT-1:0] pipe_d, pipe_q;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Clearing on reset drops every in-flight read so none ever returns.
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch with a burst guard, draw/host
// round-robin, registered memory command and tagged read return.
// Optional per-requester statistics are enabled with `define VRAM_ARB_STATS_EN.
module vram_arbiter
    import vdp_pkg::*;
#(
    parameter int ADDRW          = 16,
    parameter int DATAW          = 16,
    parameter int RD_LAT         = 2,
    parameter int MAX_DISP_BURST = 8
) (
    input  logic                     clk_draw,
    input  logic                     rst_draw,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       we,
    input  logic [NUM_REQ*ADDRW-1:0] addr,
    input  logic [NUM_REQ*DATAW-1:0] wdata,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       rvalid,
    output logic [DATAW-1:0]         rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRW-1:0]         mem_addr,
    output logic [DATAW-1:0]         mem_wdata,
    input  logic [DATAW-1:0]         mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    stat_grants,
    output logic [15:0]              stat_disp_stall
`endif
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_DISP_BURST);

    logic [ADDRW-1:0] addr_a  [NUM_REQ];
    logic [DATAW-1:0] wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*ADDRW +: ADDRW];
        assign wdata_a[g] = wdata[g*DATAW +: DATAW];
    end

    // rr_last: 1 = host was the last round-robin grant, so draw goes next.
    logic             rr_last_d, rr_last_q;
    logic [7:0]       disp_burst_d, disp_burst_q;
    logic             nd_req, guard_trip, gnt_any;
    logic [NUM_REQ-1:0] gnt;
    vram_req_e        sel;

    always_comb begin
        gnt        = '0;
        sel        = REQ_DISP;
        nd_req     = req[1] | req[2];
        guard_trip = nd_req && (disp_burst_q == BURST_MAX);
        if (rst_draw) begin
            gnt = '0;
        end else if (req[0] && !guard_trip) begin
            gnt[0] = 1'b1;
            sel    = REQ_DISP;
        end else if (req[1] && (!req[2] || rr_last_q)) begin
            gnt[1] = 1'b1;
            sel    = REQ_DRAW;
        end else if (req[2]) begin
            gnt[2] = 1'b1;
            sel    = REQ_HOST;
        end
        gnt_any = |gnt;

        // Counts display grants only while someone else is waiting.
        disp_burst_d = (nd_req && gnt[0]) ? disp_burst_q + 8'd1 : 8'd0;

        rr_last_d = rr_last_q;
        if (gnt[2]) begin
            rr_last_d = 1'b1;
        end else if (gnt[1]) begin
            rr_last_d = 1'b0;
        end
    end

    assign ack = gnt;

    logic             mem_en_d, mem_en_q;
    logic             mem_we_d, mem_we_q;
    logic [ADDRW-1:0] mem_addr_d, mem_addr_q;
    logic [DATAW-1:0] mem_wdata_d, mem_wdata_q;
    vram_tag_t        cmd_tag_d, cmd_tag_q;

    always_comb begin
        mem_en_d    = gnt_any;
        mem_we_d    = gnt_any & we[sel];
        mem_addr_d  = gnt_any ? addr_a[sel]  : mem_addr_q;
        mem_wdata_d = gnt_any ? wdata_a[sel] : mem_wdata_q;
        cmd_tag_d.valid = gnt_any & ~we[sel];
        cmd_tag_d.id    = sel;
    end

    // The command-stage tag lines up with mem_en; the pipe adds RD_LAT more.
    vram_tag_t rd_tag;

    vram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk_draw (clk_draw),
        .rst_draw (rst_draw),
        .tag_in   (cmd_tag_q),
        .tag_out  (rd_tag)
    );

    logic [NUM_REQ-1:0] rvalid_d, rvalid_q;
    logic [DATAW-1:0]   rdata_d, rdata_q;

    always_comb begin
        rvalid_d = '0;
        if (rd_tag.valid) begin
            rvalid_d[rd_tag.id] = 1'b1;
        end
        rdata_d = rd_tag.valid ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            rr_last_q    <= 1'b1;
            disp_burst_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cmd_tag_q    <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
        end else begin
            rr_last_q    <= rr_last_d;
            disp_burst_q <= disp_burst_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cmd_tag_q    <= cmd_tag_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;

`ifdef VRAM_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_grants_d, stat_grants_q;
    logic [15:0]              stat_stall_d, stat_stall_q;

    always_comb begin
        stat_grants_d = stat_grants_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                stat_grants_d[i] = sat_inc16(stat_grants_q[i]);
            end
        end
        stat_stall_d = (req[0] && !gnt[0]) ? sat_inc16(stat_stall_q) : stat_stall_q;
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            stat_grants_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_grants     = stat_grants_q;
    assign stat_disp_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, single read, round-robin, burst
// guard, display streaming, interleaved read/write and mid-flight reset.
module tb_vram_arbiter;

    logic        clk_draw;
    logic        rst_draw;
    logic [2:0]  req, we, ack, rvalid;
    logic [47:0] addr, wdata;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;
    logic [15:0] rd_p1, rd_p2;
`ifdef VRAM_ARB_STATS_EN
    logic [47:0] stat_grants;
    logic [15:0] stat_disp_stall;
`endif

    int checks = 0;
    int errors = 0;

    vram_arbiter #(
        .ADDRW(16), .DATAW(16), .RD_LAT(2), .MAX_DISP_BURST(8)
    ) dut (
`ifdef VRAM_ARB_STATS_EN
        .stat_grants     (stat_grants),
        .stat_disp_stall (stat_disp_stall),
`endif
        .clk_draw  (clk_draw),
        .rst_draw  (rst_draw),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk_draw = 1'b0;
        forever #5 clk_draw = ~clk_draw;
    end

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A00);
    endfunction

    // Memory with RD_LAT=2: data valid two cycles after the mem_en cycle.
    always @(posedge clk_draw) begin
        rd_p1 <= rd_model(mem_addr);
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    task automatic step();
        @(posedge clk_draw);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req      = '0;
        rst_draw = 1'b1;
        step();
        step();
        rst_draw = 1'b0;
    endtask

    initial begin
        rst_draw = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;
        step();
        step();

        // Reset state, including ack suppressed while requests are present
        req = 3'b111;
        @(negedge clk_draw);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        step();
        req = '0;
        rst_draw = 1'b0;
        @(negedge clk_draw);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);

        // Single draw read of 0x0040
        step();
        req = 3'b010; we = 3'b000; addr[16 +: 16] = 16'h0040;
        @(negedge clk_draw);
        chk("t1_ack", 32'(ack), 32'h2);
        step();
        req = '0;
        @(negedge clk_draw);
        chk("t1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_mem_we", 32'(mem_we), 32'h0);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0040);
        chk("t1_ack_idle", 32'(ack), 32'h0);
        step();
        @(negedge clk_draw);
        chk("t1_rvalid_c2", 32'(rvalid), 32'h0);
        step();
        @(negedge clk_draw);
        chk("t1_rvalid_c3", 32'(rvalid), 32'h0);
        step();
        @(negedge clk_draw);
        chk("t1_rvalid_c4", 32'(rvalid), 32'h2);
        chk("t1_rdata_c4", 32'(rdata), 32'hBEEF);
        step();
        @(negedge clk_draw);
        chk("t1_rvalid_c5", 32'(rvalid), 32'h0);

        // Draw and host contend: draw first after reset, then alternate
        do_reset();
        we = 3'b110;
        for (int i = 0; i < 6; i++) begin
            req = 3'b110;
            @(negedge clk_draw);
            chk($sformatf("rr_%0d", i), 32'(ack), (i % 2 == 0) ? 32'h2 : 32'h4);
            step();
        end

        // All three: 8 display, draw, 8 display, host
        do_reset();
        we = 3'b000;
        for (int i = 0; i < 18; i++) begin
            req = 3'b111;
            @(negedge clk_draw);
            chk($sformatf("burst_%0d", i), 32'(ack),
                (i % 9 < 8) ? 32'h1 : ((i < 9) ? 32'h2 : 32'h4));
            step();
        end
        req = '0;
`ifdef VRAM_ARB_STATS_EN
        chk("stat_stall", 32'(stat_disp_stall), 32'd2);
        chk("stat_gnt_disp", 32'(stat_grants[0 +: 16]), 32'd16);
        chk("stat_gnt_draw", 32'(stat_grants[16 +: 16]), 32'd1);
        chk("stat_gnt_host", 32'(stat_grants[32 +: 16]), 32'd1);
`endif

        // Display alone for 20 cycles: never stalled, burst counter idle
        for (int i = 0; i < 20; i++) begin
            req = 3'b001;
            @(negedge clk_draw);
            chk($sformatf("disp_%0d", i), 32'(ack), 32'h1);
            step();
        end
`ifdef VRAM_ARB_STATS_EN
        chk("stat_stall_disp_only", 32'(stat_disp_stall), 32'd2);
`endif
        // A full 8-grant display run afterwards shows the burst count stayed 0
        for (int i = 0; i < 9; i++) begin
            req = 3'b111;
            @(negedge clk_draw);
            chk($sformatf("post_%0d", i), 32'(ack), (i < 8) ? 32'h1 : 32'h2);
            step();
        end
        req = '0;

        // Display read 0x10, host write 0x20, draw read 0x30
        do_reset();
        req = 3'b001; we = 3'b000; addr[0 +: 16] = 16'h0010;
        @(negedge clk_draw);
        chk("t5_ack0", 32'(ack), 32'h1);
        step();
        req = 3'b100; we = 3'b100; addr[32 +: 16] = 16'h0020; wdata[32 +: 16] = 16'h1234;
        @(negedge clk_draw);
        chk("t5_ack1", 32'(ack), 32'h4);
        chk("t5_c1_en", 32'(mem_en), 32'h1);
        chk("t5_c1_addr", 32'(mem_addr), 32'h0010);
        chk("t5_c1_we", 32'(mem_we), 32'h0);
        step();
        req = 3'b010; we = 3'b000; addr[16 +: 16] = 16'h0030;
        @(negedge clk_draw);
        chk("t5_ack2", 32'(ack), 32'h2);
        chk("t5_c2_we", 32'(mem_we), 32'h1);
        chk("t5_c2_addr", 32'(mem_addr), 32'h0020);
        chk("t5_c2_wdata", 32'(mem_wdata), 32'h1234);
        step();
        req = '0;
        @(negedge clk_draw);
        chk("t5_c3_addr", 32'(mem_addr), 32'h0030);
        chk("t5_c3_we", 32'(mem_we), 32'h0);
        step();
        @(negedge clk_draw);
        chk("t5_c4_rvalid", 32'(rvalid), 32'h1);
        chk("t5_c4_rdata", 32'(rdata), 32'h5A10);
        chk("t5_c4_en_idle", 32'(mem_en), 32'h0);
        chk("t5_c4_addr_hold", 32'(mem_addr), 32'h0030);
        step();
        @(negedge clk_draw);
        chk("t5_c5_rvalid", 32'(rvalid), 32'h0);
        step();
        @(negedge clk_draw);
        chk("t5_c6_rvalid", 32'(rvalid), 32'h2);
        chk("t5_c6_rdata", 32'(rdata), 32'h5A30);
        step();
        @(negedge clk_draw);
        chk("t5_c7_rvalid", 32'(rvalid), 32'h0);

        // Three reads in flight, then a one-cycle reset
        step();
        req = 3'b010; we = 3'b000; addr[16 +: 16] = 16'h0040;
        @(negedge clk_draw);
        chk("t6_ack0", 32'(ack), 32'h2);
        step();
        req = 3'b100; addr[32 +: 16] = 16'h0050;
        @(negedge clk_draw);
        chk("t6_ack1", 32'(ack), 32'h4);
        step();
        req = 3'b001; addr[0 +: 16] = 16'h0060;
        @(negedge clk_draw);
        chk("t6_ack2", 32'(ack), 32'h1);
        step();
        req = '0; rst_draw = 1'b1;
        @(negedge clk_draw);
        chk("t6_c3_rvalid", 32'(rvalid), 32'h0);
        step();
        rst_draw = 1'b0;
        @(negedge clk_draw);
        chk("t6_rst_rvalid", 32'(rvalid), 32'h0);
        chk("t6_rst_mem_en", 32'(mem_en), 32'h0);
        chk("t6_rst_mem_we", 32'(mem_we), 32'h0);
        chk("t6_rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("t6_rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("t6_rst_rdata", 32'(rdata), 32'h0);
        chk("t6_rst_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk_draw);
            chk($sformatf("t6_drop_%0d", i), 32'(rvalid), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter in the `clk_draw` domain of the `vdp`. It shares one video memory port between three requesters: display line fetch, draw engine and host writes. Display fetch has deadline priority, with a bounded-burst guard. Draw and host are served round-robin, and read data is returned to the issuing requester over a fixed-latency tagged pipeline.

## Interface
Parameters:
- `ADDRW`, 16, VRAM word address width
- `DATAW`, 16, VRAM word width
- `RD_LAT`, 2, memory read latency in cycles from `mem_en` to `mem_rdata` valid (legal 1–4)
- `MAX_DISP_BURST`, 8, max consecutive display grants while another requester waits (legal 1–255)

Ports (requester index 0 = display, 1 = draw, 2 = host):
- `clk_draw`  in  1  sole clock
- `rst_draw`  in  1  reset, synchronous, active-high
- `req`  in  3  request per requester; held until acked
- `we`  in  3  1 = write, 0 = read; per requester
- `addr`  in  3*ADDRW  packed addresses, requester i at `[i*ADDRW +: ADDRW]`
- `wdata`  in  3*DATAW  packed write data, same packing
- `ack`  out  3  one-hot grant this cycle (combinational from `req` + state)
- `rvalid`  out  3  one-hot: `rdata` belongs to requester i
- `rdata`  out  DATAW  read data, broadcast to all requesters
- `mem_en`, `mem_we`  out  1 each  memory command
- `mem_addr`  out  ADDRW
- `mem_wdata`  out  DATAW
- `mem_rdata`  in  DATAW

## Operation
- At most one `ack` bit set per cycle. `ack[i]` implies `req[i]`. A requester must hold `req`/`we`/`addr`/`wdata` stable until acked, and may drop `req` or present a new request in the cycle after ack.
- Priority:
  - Display wins whenever `req[0]`, unless the burst guard is tripped.
  - Otherwise draw and host alternate. `rr_last` (1 bit) records which of them was last granted; the other is preferred when both request. If only one requests, it is granted regardless of `rr_last`.
- Burst guard:
  - `disp_burst` (8-bit) increments on every display grant made while `req[1]|req[2]`.
  - It clears on any non-display grant, or on any cycle with no non-display requester.
  - When `disp_burst == MAX_DISP_BURST` and `req[1]|req[2]`, display is refused for one cycle and the round-robin choice is granted; `disp_burst` then clears.
- Command register: the granted request is registered onto `mem_*` the cycle after ack. `mem_en` is 0 on idle cycles. `mem_addr`/`mem_wdata` hold their last value when idle.
- Read return:
  - Each granted read pushes (valid, requester id) into a tag pipeline of depth `RD_LAT`, aligned with `mem_en`.
  - On exit, `rvalid[id]` = 1 and `rdata` = `mem_rdata`, registered.
  - Writes push a null tag.
- Reset: `ack` = 0, `rvalid` = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `rdata` = 0, `rr_last` = host (draw preferred first), `disp_burst` = 0. Tag pipeline cleared: in-flight reads are dropped and never return. Reset asserted mid-burst produces no `rvalid` afterwards for pre-reset reads.

## Timing
- Ack: same cycle as `req` when granted (combinational path `req` -> `ack`).
- Memory command: cycle c+1 for ack at cycle c.
- Read data: `rvalid` at cycle c+2+`RD_LAT` for ack at c; back-to-back reads return one per cycle, in grant order.
- Throughput: one access per cycle sustained. No bubbles between different requesters.
- Simultaneous all-three requests: display acked; after `MAX_DISP_BURST` consecutive display acks, one slot goes to the round-robin winner.

## Configuration
- `VRAM_ARB_STATS_EN` defined:
  - Adds outputs `stat_grants` (3×16, packed, saturating at 16'hFFFF, per requester) and `stat_disp_stall` (16, saturating: cycles with `req[0] && !ack[0]`).
  - All counters clear on `rst_draw`.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- `vdp_pkg` holds:
  - `NUM_REQ` = 3
  - enum `vram_req_e` (`REQ_DISP`=0, `REQ_DRAW`=1, `REQ_HOST`=2)
  - tag struct `vram_tag_t` {valid, id[1:0]}
- Sub-module `vram_rd_tag_pipe`: `RD_LAT`-deep shift register of `vram_tag_t`, synchronous clear on reset.
- The grant logic and command register stay in `vram_arbiter`.

## Test plan
- Single draw read of addr 0x0040, memory model returns 0xBEEF; `RD_LAT`=2 -> `ack[1]` at c, `mem_en` at c+1, `rvalid[1]` with `rdata`=0xBEEF at c+4.
- Draw and host both continuously requesting, display idle -> acks alternate draw, host, draw, … starting with draw after reset.
- All three continuously requesting, `MAX_DISP_BURST`=8 -> pattern 8 display acks, 1 draw, 8 display, 1 host; `stat_disp_stall` (with `VRAM_ARB_STATS_EN`) increments by 1 per pattern.
- Display only, 20 consecutive requests -> 20 consecutive acks, no stall, `disp_burst` stays 0.
- Interleaved reads display@0x10, host write@0x20, draw read@0x30 -> `rvalid` sequence [0], none, [1] with correct data; write produces no `rvalid`.
- Three reads in flight, `rst_draw` pulsed one cycle -> no `rvalid` afterwards; all outputs at reset values the cycle after reset.
